// File: rtl/rom_stream_reader_pkg.sv
// Shared helpers for the ROM stream reader slice.
package rom_stream_reader_pkg;

  // Increment with fold-back to zero at the modulus (ROM address wrap).
  function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/rom_stream_reader_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push into a full FIFO is legal only with a simultaneous pop.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3,
  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 do_push, do_pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign full     = (count == CNT_WIDTH'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/rom_stream_reader.sv
// Issues sequential ROM reads under a credit check and re-emits the returned words as a
// ready/valid stream with a last flag.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int DEPTH          = 33,
  parameter int WIDTH          = 32,
  parameter int MEMORY_LATENCY = 2,
  parameter int FIFO_DEPTH     = MEMORY_LATENCY + 1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_valid,
  input  logic [WIDTH-1:0]      rom_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last
);

  if (FIFO_DEPTH < MEMORY_LATENCY + 1) begin : g_depth_check
    $error("FIFO_DEPTH must be at least MEMORY_LATENCY+1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int SUMW = FCW + 1;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  num_q, issued, returned, popped, last_idx;
  logic [FCW-1:0]        in_flight, fifo_count;
  logic [SUMW-1:0]       credit_used;
  logic                  fifo_full, fifo_empty, pop, accept, credit_ok, done_set;
  logic [WIDTH:0]        head;

  assign accept    = (state == IDLE) && start;
  assign last_idx  = num_q - CNT_WIDTH'(1);
  assign pop       = out_valid && out_ready;
  // A word leaving the FIFO this cycle frees its slot long before any new request can return.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count} - SUMW'(pop);
  assign credit_ok   = credit_used < SUMW'(FIFO_DEPTH);
  assign busy      = (state != IDLE);
  assign rom_addr  = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = head[WIDTH-1:0];
  assign out_last  = out_valid && head[WIDTH];

  always_comb begin
    state_next = state;
    rom_ready  = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        if (num_words == '0) done_set = 1'b1;
        else                 state_next = ISSUE;
      end
      ISSUE: begin
        rom_ready = credit_ok;
        if (credit_ok && issued == last_idx) state_next = DRAIN;
      end
      DRAIN: if (pop && out_last) begin
        state_next = IDLE;
        done_set   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      addr_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      returned  <= '0;
      popped    <= '0;
      in_flight <= '0;
    end else begin
      state <= state_next;
      done  <= done_set;
      if (accept) begin
        addr_q   <= base_addr;
        num_q    <= num_words;
        issued   <= '0;
        returned <= '0;
        popped   <= '0;
      end else begin
        if (rom_ready) begin
          addr_q <= ADDR_WIDTH'(wrap_inc(32'(addr_q), $unsigned(DEPTH)));
          issued <= issued + CNT_WIDTH'(1);
        end
        if (rom_valid) returned <= returned + CNT_WIDTH'(1);
        if (pop)       popped   <= popped + CNT_WIDTH'(1);
      end
      case ({rom_ready, rom_valid})
        2'b10:   in_flight <= in_flight + FCW'(1);
        2'b01:   in_flight <= in_flight - FCW'(1);
        default: ;
      endcase
    end
  end

  // The last flag is attached on return; returned and popped advance in lockstep order.
  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rom_valid),
    .push_data ({returned == last_idx, rom_dout}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_len_ok:     assert property (@(posedge clk) disable iff (rst) accept |-> num_words <= CNT_WIDTH'(DEPTH));
  a_valid_owed: assert property (@(posedge clk) disable iff (rst) rom_valid |-> in_flight != '0);
  a_slot_free:  assert property (@(posedge clk) disable iff (rst) rom_valid |-> (!fifo_full || pop));
  a_popped_ok:  assert property (@(posedge clk) disable iff (rst) pop |-> popped < num_q);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a two-stage-latency ROM model.
module tb_rom_stream_reader;

  localparam int AW = 6;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst, start, out_ready, rom_valid;
  logic [AW-1:0] base_addr, rom_addr;
  logic [CW-1:0] num_words;
  logic [31:0]   rom_dout, out_data;
  logic          busy, done, rom_ready, out_valid, out_last;

  rom_stream_reader #(
    .DEPTH          (33),
    .WIDTH          (32),
    .MEMORY_LATENCY (2),
    .FIFO_DEPTH     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .rom_ready (rom_ready),
    .rom_addr  (rom_addr),
    .rom_valid (rom_valid),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // ROM model: request seen at one edge returns two edges later.
  logic          v1, v2;
  logic [AW-1:0] a1, a2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      v1 <= rom_ready; a1 <= rom_addr;
      v2 <= v1;        a2 <= a1;
    end
  end
  assign rom_valid = v2;
  assign rom_dout  = 32'hA000_0000 | {26'b0, a2};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [32:0] sb[$];
  int          addr_log[$];
  int          rr_count = 0, done_count = 0, done_cyc = -1, first_valid_cyc = -1;
  int          last_cyc = -1, start_edge = 0, max_occ = 0, occ;
  bit          busy_any = 0, busy_at_done = 0;
  logic [32:0] exp_word;

  // Monitor: pops the scoreboard on each accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_ready) begin
        rr_count++;
        addr_log.push_back(int'(rom_addr));
      end
      if (busy) busy_any = 1;
      if (done) begin
        done_count++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      occ = int'(dut.in_flight) + int'(dut.fifo_count);
      if (occ > max_occ) max_occ = occ;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {31'b0, out_last, out_data}, 64'hDEAD);
        end else begin
          exp_word = sb.pop_front();
          check("word_data", out_data, exp_word[31:0]);
          check("word_last", out_last, exp_word[32]);
          if (out_last) last_cyc = cyc;
        end
      end
    end
  end

  int         ready_mode = 0;
  logic [3:0] pattern = 4'b1001;
  int         pidx = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       begin out_ready = pattern[pidx % 4]; pidx++; end
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  int rr_start, done_start;

  task automatic run_burst(input int base, input int num);
    int a;
    @(posedge clk); #1;
    rr_start        = rr_count;
    done_start      = done_count;
    first_valid_cyc = -1;
    busy_any        = 0;
    addr_log.delete();
    for (int i = 0; i < num; i++) begin
      a = (base + i) % 33;
      sb.push_back({(i == num - 1), 32'hA000_0000 | a});
    end
    start      = 1'b1;
    base_addr  = AW'(base);
    num_words  = CW'(num);
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && done_count == done_start; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check({name, "_done_once"}, done_count - done_start, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},      busy,      0);
    check({name, "_done"},      done,      0);
    check({name, "_rom_ready"}, rom_ready, 0);
    check({name, "_rom_addr"},  rom_addr,  0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_last"},  out_last,  0);
    check({name, "_out_data"},  out_data,  0);
  endtask

  int exp_wrap[6] = '{30, 31, 32, 0, 1, 2};
  bit hit;
  int done_before;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Full burst, free-flowing
    run_burst(0, 33);
    wait_done("full");
    check("full_first_latency", first_valid_cyc - start_edge, 3);
    check("full_consecutive", last_cyc - first_valid_cyc, 32);
    check("full_done_timing", done_cyc - last_cyc, 1);
    check("full_busy_at_done", busy_at_done, 0);
    check("full_rom_reads", rr_count - rr_start, 33);

    // Backpressure 1,0,0,1
    ready_mode = 1;
    max_occ    = 0;
    run_burst(5, 10);
    wait_done("bp");
    check("bp_rom_reads", rr_count - rr_start, 10);
    check("bp_occupancy_le_3", max_occ <= 3, 1);
    ready_mode = 0;

    // Wrap
    run_burst(30, 6);
    wait_done("wrap");
    check("wrap_addr_count", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) check("wrap_addr", addr_log[i], exp_wrap[i]);

    // Zero length
    run_burst(7, 0);
    wait_done("zero");
    check("zero_done_timing", done_cyc - start_edge, 0);
    check("zero_rom_reads", rr_count - rr_start, 0);
    check("zero_busy_never", busy_any, 0);

    // Start while busy is ignored
    run_burst(5, 4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(20); num_words = CW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start_rom_reads", rr_count - rr_start, 4);

    // Reset with two words in flight and one buffered
    ready_mode = 2;
    repeat (2) @(posedge clk);
    run_burst(0, 10);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dut.in_flight == 2 && dut.fifo_count == 1) begin hit = 1; break; end
    end
    check("reset_setup_reached", hit, 1);
    done_before = done_count;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    check("midreset_no_done", done_count - done_before, 0);
    run_burst(0, 4);
    wait_done("after_reset");
    check("after_reset_rom_reads", rr_count - rr_start, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
